// File: rtl/gate_equiv_pkg.sv
// Shared definitions for the gate-equivalence truth-table sequencer.
//   state_t    : sequencer FSM states
//   NUM_VECS   : vectors per run for the default 2-input configuration
//   num_vecs() : vectors per run for an arbitrary stimulus width
//   cnt_width(): register width able to hold 0..maxval (never below 1 bit)
package gate_equiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned DEF_N_INPUTS = 2;
  localparam int unsigned NUM_VECS     = 2 ** DEF_N_INPUTS;

  function automatic int unsigned num_vecs(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // A zero-length counter is not representable, so 0 and 1 both map to 1 bit.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    if (maxval < 2) begin
      return 1;
    end
    return $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/gate_equiv_sequencer_settle_timer.sv
// Settle-wait down-counter for the gate-equivalence sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter for a fresh settle interval
//   tick       : one settle cycle has elapsed (only honoured while non-zero)
//   expired    : counter has reached zero; the settle interval is over
// The counter is loaded with SETTLE_CYCLES-1 so that "expired" is already
// visible during the last settle cycle and the FSM leaves SETTLE after
// exactly SETTLE_CYCLES cycles.
module settle_timer
  import gate_equiv_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = cnt_width(SETTLE_CYCLES);
  localparam int unsigned LOAD_INT = (SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0;
  localparam logic [W-1:0] LOAD_VAL = W'(LOAD_INT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_equiv_sequencer.sv
// Exhaustive truth-table sequencer for combinational gate-equivalence checks.
// Drives every vector 0 .. 2**N_INPUTS-1 onto stim, waits SETTLE_CYCLES,
// compares NUM_PAIRS lhs/rhs outputs in parallel and accumulates the results.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle run request, honoured only when idle
//   abort          : terminates an active run (no done pulse, pass cleared)
//   lhs, rhs       : reference / alternative gate outputs, bit i = pair i
//   stim           : registered stimulus to both gate networks
//   busy           : run in progress (APPLY/SETTLE/CHECK/DONE)
//   done           : one-cycle pulse after a completed run
//   pass           : last completed run had no mismatches
//   mismatch_mask  : sticky OR of lhs^rhs over checked vectors
//   fail_count     : number of vectors with any mismatching pair
//   first_fail_vec : stim of the first mismatching vector (valid if fail_count != 0)
module gate_equiv_sequencer
  import gate_equiv_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned NUM_PAIRS     = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_PAIRS-1:0]  lhs,
  input  logic [NUM_PAIRS-1:0]  rhs,
  output logic [N_INPUTS-1:0]   stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_PAIRS-1:0]  mismatch_mask,
  output logic [N_INPUTS:0]     fail_count,
  output logic [N_INPUTS-1:0]   first_fail_vec
);

  // One extra bit so the vector index can never wrap before terminal detection.
  localparam int unsigned   VW         = N_INPUTS + 1;
  localparam logic [VW-1:0] LAST_VEC   = VW'(num_vecs(N_INPUTS) - 1);
  localparam logic          HAS_SETTLE = (SETTLE_CYCLES > 0);

  state_t                state;
  logic [VW-1:0]         vec;
  logic [NUM_PAIRS-1:0]  diff;
  logic                  timer_load;
  logic                  timer_tick;
  logic                  timer_expired;

  assign diff       = lhs ^ rhs;
  assign timer_load = (state == ST_APPLY)  && !abort;
  assign timer_tick = (state == ST_SETTLE) && !abort;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // busy is tracked alongside the state so it is registered and equals
  // (state != IDLE) on every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      vec            <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_mask  <= '0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // In IDLE an abort only masks a simultaneous start; results are kept.
        if (state != ST_IDLE) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          pass  <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state          <= ST_APPLY;
              busy           <= 1'b1;
              vec            <= '0;
              pass           <= 1'b0;
              mismatch_mask  <= '0;
              fail_count     <= '0;
              first_fail_vec <= '0;
            end
          end
          ST_APPLY: begin
            stim <= vec[N_INPUTS-1:0];
            if (HAS_SETTLE) begin
              state <= ST_SETTLE;
            end else begin
              state <= ST_CHECK;
            end
          end
          ST_SETTLE: begin
            if (timer_expired) begin
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            mismatch_mask <= mismatch_mask | diff;
            if (|diff) begin
              fail_count <= fail_count + 1'b1;
              if (fail_count == '0) begin
                first_fail_vec <= vec[N_INPUTS-1:0];
              end
            end
            if (vec == LAST_VEC) begin
              state <= ST_DONE;
            end else begin
              vec   <= vec + 1'b1;
              state <= ST_APPLY;
            end
          end
          ST_DONE: begin
            // fail_count already includes the final CHECK, so it alone decides.
            done  <= 1'b1;
            pass  <= (fail_count == '0);
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_equiv_sequencer.sv
module tb_gate_equiv_sequencer;

  localparam int NV = 4;

  typedef struct packed {
    logic [1:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] mask;
    logic [2:0] cnt;
    logic [1:0] ffv;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0, abort1 = 1'b0;
  logic [3:0] lhs0, rhs0, lhs1, rhs1;
  logic [1:0] stim0, stim1, ffv0, ffv1;
  logic busy0, busy1, done0, done1, pass0, pass1;
  logic [3:0] mask0, mask1;
  logic [2:0] cnt0, cnt1;
  int fault0 = 0, fault1 = 0;

  int vectors = 0;
  int misc = 0;
  int edges = 0;
  int t0 [2];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // Gate networks under comparison: a = stim[1], b = stim[0].
  function automatic logic [3:0] ref_lhs(input logic [1:0] v);
    logic a, b;
    a = v[1]; b = v[0];
    return {a | b, a & b, ~(a | b), ~(a & b)};
  endfunction

  function automatic logic [3:0] impl_rhs(input logic [1:0] v, input int f);
    logic a, b;
    logic [3:0] r;
    a = v[1]; b = v[0];
    r[0] = ~a | ~b;
    r[1] = ~a & ~b;
    r[2] = ~(~a | ~b);
    r[3] = ~(~(a & a) & ~(b & b));
    if (f == 1) r[1] = 1'b0;
    if (f == 2) r[0] = ~r[0];
    return r;
  endfunction

  assign lhs0 = ref_lhs(stim0);
  assign rhs0 = impl_rhs(stim0, fault0);
  assign lhs1 = ref_lhs(stim1);
  assign rhs1 = impl_rhs(stim1, fault1);

  gate_equiv_sequencer #(.N_INPUTS(2), .NUM_PAIRS(4), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .lhs(lhs0), .rhs(rhs0),
    .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .mismatch_mask(mask0),
    .fail_count(cnt0), .first_fail_vec(ffv0));

  gate_equiv_sequencer #(.N_INPUTS(2), .NUM_PAIRS(4), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .lhs(lhs1), .rhs(rhs1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .mismatch_mask(mask1),
    .fail_count(cnt1), .first_fail_vec(ffv1));

  // Expected outputs k edges after the edge that accepted start, for a run
  // with p edges per vector (settle + 2) and fault mode f.
  function automatic obs_t model_at(input int k, input int p, input int f,
                                    input logic [1:0] prev_stim);
    obs_t e;
    int last, nchk, sv;
    logic [3:0] d;
    e = '0;
    last = NV * p;
    sv = (k - 1) / p;
    if (sv > NV - 1) sv = NV - 1;
    e.stim = (k == 0) ? prev_stim : 2'(sv);
    e.busy = (k <= last);
    e.done = (k == last + 1);
    nchk = k / p;
    if (nchk > NV) nchk = NV;
    for (int v = 0; v < nchk; v++) begin
      d = ref_lhs(2'(v)) ^ impl_rhs(2'(v), f);
      e.mask = e.mask | d;
      if (d != 4'b0000) begin
        if (e.cnt == 3'd0) e.ffv = 2'(v);
        e.cnt = e.cnt + 3'd1;
      end
    end
    e.pass = (k > last) && (e.cnt == 3'd0);
    return e;
  endfunction

  obs_t ex [2];
  int   k  [2];
  bit   act[2];
  int   ef [2];
  logic [1:0] pstim [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      ex[d] = '0; k[d] = 0; act[d] = 1'b0; ef[d] = 0; pstim[d] = 2'b00;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        logic st, ab;
        int p;
        st = (d == 0) ? start0 : start1;
        ab = (d == 0) ? abort0 : abort1;
        p  = (d == 0) ? 3 : 2;
        if (!rst_n) begin
          ex[d] = '0;
          act[d] = 1'b0;
        end else if (act[d]) begin
          if (ab) begin
            act[d] = 1'b0;
            ex[d].busy = 1'b0;
            ex[d].done = 1'b0;
            ex[d].pass = 1'b0;
          end else begin
            k[d] = k[d] + 1;
            ex[d] = model_at(k[d], p, ef[d], pstim[d]);
            if (k[d] == NV * p + 1) act[d] = 1'b0;
          end
        end else begin
          ex[d].done = 1'b0;
          if (st && !ab) begin
            act[d] = 1'b1;
            k[d] = 0;
            pstim[d] = ex[d].stim;
            ef[d] = (d == 0) ? fault0 : fault1;
            ex[d] = model_at(0, p, ef[d], pstim[d]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      misc++;
      $display("FAIL dut%0d %s: got %0h, want %0h (t=%0t)", d, nm, a, e, $time);
    end
  endtask

  function automatic obs_t actual(input int d);
    obs_t o;
    if (d == 0) o = {stim0, busy0, done0, pass0, mask0, cnt0, ffv0};
    else        o = {stim1, busy1, done1, pass1, mask1, cnt1, ffv1};
    return o;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        obs_t a;
        a = actual(d);
        chk("stim", d, 32'(a.stim), 32'(ex[d].stim));
        chk("busy", d, 32'(a.busy), 32'(ex[d].busy));
        chk("done", d, 32'(a.done), 32'(ex[d].done));
        chk("pass", d, 32'(a.pass), 32'(ex[d].pass));
        chk("mismatch_mask", d, 32'(a.mask), 32'(ex[d].mask));
        chk("fail_count", d, 32'(a.cnt), 32'(ex[d].cnt));
        chk("first_fail_vec", d, 32'(a.ffv), 32'(ex[d].ffv));
      end
    end
  end

  task automatic pulse_start(input int d);
    @(negedge clk);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (d == 0) start0 = 1'b0; else start1 = 1'b0;
    t0[d] = edges;
  endtask

  task automatic wait_done(input int d, input int exp_edge, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_of(d)) seen = 1'b1;
    end
    chk(nm, d, 32'(edges - t0[d]), 32'(exp_edge));
  endtask

  task automatic count_dones(input int d, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_of(d)) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 0, 32'(busy0), 32'd0);
    chk("reset_stim", 0, 32'(stim0), 32'd0);
    chk("reset_count", 0, 32'(cnt0), 32'd0);

    // Test 1: all pairs equivalent.
    fault0 = 0;
    pulse_start(0);
    wait_done(0, 13, "t1_done_edge");
    chk("t1_pass", 0, 32'(pass0), 32'd1);
    chk("t1_mask", 0, 32'(mask0), 32'h0);
    chk("t1_count", 0, 32'(cnt0), 32'd0);

    // Test 2: rhs[1] stuck at 0 -> only vector 0 differs.
    fault0 = 1;
    pulse_start(0);
    wait_done(0, 13, "t2_done_edge");
    chk("t2_count", 0, 32'(cnt0), 32'd1);
    chk("t2_first", 0, 32'(ffv0), 32'd0);
    chk("t2_mask", 0, 32'(mask0), 32'b0010);
    chk("t2_pass", 0, 32'(pass0), 32'd0);

    // Test 3: rhs[0] inverted -> every vector differs.
    fault0 = 2;
    pulse_start(0);
    wait_done(0, 13, "t3_done_edge");
    chk("t3_count", 0, 32'(cnt0), 32'd4);
    chk("t3_first", 0, 32'(ffv0), 32'd0);
    chk("t3_mask", 0, 32'(mask0), 32'b0001);
    chk("t3_pass", 0, 32'(pass0), 32'd0);

    // Test 4: abort sampled at edge 5, then a clean run.
    fault0 = 0;
    pulse_start(0);
    repeat (4) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("t4_busy_after_abort", 0, 32'(busy0), 32'd0);
    chk("t4_pass_after_abort", 0, 32'(pass0), 32'd0);
    count_dones(0, 20, nd);
    chk("t4_no_done", 0, 32'(nd), 32'd0);
    pulse_start(0);
    wait_done(0, 13, "t4_rerun_done_edge");
    chk("t4_rerun_pass", 0, 32'(pass0), 32'd1);

    // start and abort together while idle: abort wins.
    @(negedge clk);
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    chk("idle_start_abort_busy", 0, 32'(busy0), 32'd0);
    chk("idle_start_abort_pass", 0, 32'(pass0), 32'd1);

    // Test 5a: second start at edge 4 is ignored.
    pulse_start(0);
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 13, "t5_done_edge");
    count_dones(0, 20, nd);
    chk("t5_single_done", 0, 32'(nd), 32'd0);

    // Test 5b: asynchronous reset mid-run.
    pulse_start(0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 0, 32'(busy0), 32'd0);
    chk("t5_rst_stim", 0, 32'(stim0), 32'd0);
    chk("t5_rst_mask", 0, 32'(mask0), 32'd0);
    chk("t5_rst_pass", 0, 32'(pass0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(0, 20, nd);
    chk("t5_rst_no_done", 0, 32'(nd), 32'd0);

    // Test 6: zero settle cycles.
    fault1 = 0;
    pulse_start(1);
    wait_done(1, 9, "t6_done_edge");
    chk("t6_pass", 1, 32'(pass1), 32'd1);
    chk("t6_mask", 1, 32'(mask1), 32'h0);
    chk("t6_count", 1, 32'(cnt1), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
